fu_exec: RTL and testbench



---
 rtl/fu_exec_pkg.sv | 30 +++
 rtl/fu_credit_ctr.sv | 38 +++
 rtl/fu_exec.sv | 123 ++++++++++++
 tb/tb_fu_exec.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fu_exec_pkg.sv
// fu_exec_pkg: shared definitions for the FU execution controller.
// Holds the FSM state encoding, the sign-operation selectors and the
// default datapath width.
package fu_exec_pkg;

    localparam int PATH_BITS = 32;

    localparam int OP_PASS = 0;
    localparam int OP_NEG  = 1;
    localparam int OP_ABS  = 2;
    localparam int OP_NABS = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_STALL = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // New IEEE-754 sign bit for the selected operation.
    function automatic logic sign_apply(input logic s, input int op);
        case (op)
            OP_NEG:  return ~s;
            OP_ABS:  return 1'b0;
            OP_NABS: return 1'b1;
            default: return s;
        endcase
    endfunction

endpackage

// File: rtl/fu_credit_ctr.sv
// fu_credit_ctr: saturating downstream credit counter.
// Starts full at CREDITS, counts returns up (never past CREDITS) and
// consumptions down; a return and a consumption together cancel.
module fu_credit_ctr #(
    parameter int CREDITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic       avail,
    output logic [2:0] count
);

    localparam logic [2:0] CRED_MAX = 3'(CREDITS);

    logic [2:0] cnt_q, cnt_d;

    // Next credit value: saturate at CRED_MAX on return, floor at zero on use.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec) begin
            if (cnt_q != CRED_MAX) cnt_d = cnt_q + 3'd1;
        end else if (dec && !inc) begin
            if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        end
    end

    // Credit register, full after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= CRED_MAX;
        else      cnt_q <= cnt_d;
    end

    assign avail = (cnt_q != 3'd0);
    assign count = cnt_q;

endmodule

// File: rtl/fu_exec.sv
// fu_exec: fixed-latency floating-point sign-operation controller.
// Captures the FU stage operand, waits LATENCY cycles, and completes with a
// one-cycle done/res_valid pulse once a downstream credit is available.
// Optional build macro FU_EXEC_STATS_EN adds saturating op/stall counters.
module fu_exec
    import fu_exec_pkg::*;
#(
    parameter int BITS    = PATH_BITS,
    parameter int LATENCY = 4,
    parameter int CREDITS = 2,
    parameter int OP      = OP_PASS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [BITS-1:0] data_in,
    output logic            done,
    output logic            res_valid,
    output logic [BITS-1:0] res_data,
    input  logic            res_credit_in,
    output logic            busy
`ifdef FU_EXEC_STATS_EN
    ,
    output logic [15:0]     op_count,
    output logic [15:0]     stall_count
`endif
);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [BITS-1:0] opnd_q, opnd_d;
    logic [BITS-1:0] res_q, res_d;
    logic            take;
    logic            cred_avail;
    logic [2:0]      cred_cnt;

    fu_credit_ctr #(
        .CREDITS (CREDITS)
    ) u_cred (
        .clk   (clk),
        .rst   (rst),
        .inc   (res_credit_in),
        .dec   (take),
        .avail (cred_avail),
        .count (cred_cnt)
    );

    // Next-state, countdown, operand capture and result computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    opnd_d  = data_in;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q != 4'd0)   cnt_d   = cnt_q - 4'd1;
                else if (cred_avail) take    = 1'b1;
                else                 state_d = ST_STALL;
            end
            ST_STALL: begin
                // A credit arriving this cycle is already usable here.
                if ((cred_cnt != 3'd0) || res_credit_in) take = 1'b1;
            end
            default: begin
                // DONE: valid_in still shows the finished word, so ignore it.
                state_d = ST_IDLE;
            end
        endcase
        if (take) begin
            state_d = ST_DONE;
            res_d   = {sign_apply(opnd_q[BITS-1], OP), opnd_q[BITS-2:0]};
        end
    end

    // State, counter and data registers; all cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            opnd_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
        end
    end

    assign done      = (state_q == ST_DONE);
    assign res_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign res_data  = res_q;

`ifdef FU_EXEC_STATS_EN
    logic [15:0] op_cnt_q, stall_cnt_q;

    // Saturating completion and stall-cycle counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_cnt_q    <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            if (take && (op_cnt_q != 16'hFFFF))
                op_cnt_q <= op_cnt_q + 16'd1;
            if ((state_q == ST_STALL) && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign op_count    = op_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fu_exec.sv
// tb_fu_exec: directed plus randomized bench for fu_exec. Four instances
// share the same stimulus, one per sign operation, so every result is seen
// under pass/negate/abs/nabs.
module tb_fu_exec;

    localparam int L = 4;
    localparam int C = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0;
    logic        res_credit_in = 1'b0;
    logic [31:0] data_in = 32'd0;

    logic        done      [4];
    logic        res_valid [4];
    logic        busy      [4];
    logic [31:0] res_data  [4];
`ifdef FU_EXEC_STATS_EN
    logic [15:0] op_count    [4];
    logic [15:0] stall_count [4];
`endif

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        fu_exec #(
            .BITS    (32),
            .LATENCY (L),
            .CREDITS (C),
            .OP      (g)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .valid_in      (valid_in),
            .data_in       (data_in),
            .done          (done[g]),
            .res_valid     (res_valid[g]),
            .res_data      (res_data[g]),
            .res_credit_in (res_credit_in),
            .busy          (busy[g])
`ifdef FU_EXEC_STATS_EN
            ,
            .op_count      (op_count[g]),
            .stall_count   (stall_count[g])
`endif
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    int          m_cred = C;
    int          m_ops = 0;
    int          m_stalls = 0;
    logic [31:0] m_res [4] = '{32'd0, 32'd0, 32'd0, 32'd0};

    function automatic logic [31:0] fref(input logic [31:0] d, input int op);
        case (op)
            0:       return d;
            1:       return d ^ 32'h8000_0000;
            2:       return d & 32'h7FFF_FFFF;
            default: return d | 32'h8000_0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic exp_done, input logic exp_busy);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s done[%0d]", tag, i), 32'(done[i]), 32'(exp_done));
            check($sformatf("%s res_valid[%0d]", tag, i), 32'(res_valid[i]), 32'(exp_done));
            check($sformatf("%s busy[%0d]", tag, i), 32'(busy[i]), 32'(exp_busy));
            check($sformatf("%s res_data[%0d]", tag, i), res_data[i], m_res[i]);
        end
    endtask

    task automatic check_cred(input string tag);
        check(tag, 32'(g_dut[0].u_dut.cred_cnt), 32'(m_cred));
`ifdef FU_EXEC_STATS_EN
        check({tag, " op_count"}, 32'(op_count[0]), 32'(m_ops));
        check({tag, " stall_count"}, 32'(stall_count[0]), 32'(m_stalls));
`endif
    endtask

    // One operation. ret_at: edge index (relative to the capture edge) at which
    // a credit pulse is sampled, or -1 for none. Rules the caller keeps:
    // ret_at in {-1, L, L+1} when credit is available, ret_at > L when not.
    task automatic run_op(input logic [31:0] d, input int ret_at, input bit keep_valid,
                          output int unsigned done_cyc);
        int e;
        int kmax;
        valid_in = 1'b1;
        data_in  = d;
        e    = (m_cred > 0) ? L : ret_at;
        kmax = (ret_at > e) ? ret_at + 1 : e + 1;
        done_cyc = 0;
        tick();
        check_outputs("capture", 1'b0, 1'b1);
        for (int k = 1; k <= kmax; k++) begin
            res_credit_in = (k == ret_at);
            tick();
            res_credit_in = 1'b0;
            if (k == e) begin
                done_cyc = cyc;
                for (int i = 0; i < 4; i++) m_res[i] = fref(d, i);
            end
            check_outputs($sformatf("op k=%0d", k), k == e, k <= e);
            if (k == e) begin
                if (!keep_valid) valid_in = 1'b0;
                data_in = $urandom;
            end
        end
        if (m_cred > 0) begin
            m_cred = m_cred - 1 + ((ret_at >= 1) ? 1 : 0);
            if (m_cred > C) m_cred = C;
        end else begin
            m_stalls += e - L;
        end
        m_ops++;
        check_cred("cred after op");
    endtask

    task automatic pulse_credit(input int n);
        for (int i = 0; i < n; i++) begin
            res_credit_in = 1'b1;
            tick();
            res_credit_in = 1'b0;
            if (m_cred < C) m_cred++;
            check("idle done", 32'(done[0]), 32'd0);
            check_cred("cred after return");
        end
    endtask

    initial begin
        int unsigned dA, dB, dx;
        int r;

        // Reset state.
        tick();
        check_outputs("reset", 1'b0, 1'b0);
        check_cred("reset cred");
        rst = 1'b1;
        tick();
        check_outputs("post-reset idle", 1'b0, 1'b0);

        // Pass / negate, then abs; then a third op with no credit stalls.
        run_op(32'h3F80_0000, -1, 1'b0, dx);
        check("pass 1.0", res_data[0], 32'h3F80_0000);
        check("neg 1.0", res_data[1], 32'hBF80_0000);
        run_op(32'hC000_0000, -1, 1'b0, dx);
        check("abs -2.0", res_data[2], 32'h4000_0000);
        run_op(32'h1234_5678, L + 3, 1'b0, dx);

        // Return coincident with DONE entry at cred = 1 leaves cred at 1.
        pulse_credit(1);
        run_op(32'hDEAD_BEEF, L, 1'b0, dx);
        check("coincident cred", 32'(g_dut[0].u_dut.cred_cnt), 32'd1);

        // Returns while full are ignored.
        pulse_credit(3);
        check("saturated cred", 32'(g_dut[0].u_dut.cred_cnt), 32'(C));

        // Back-to-back operands with valid held through DONE.
        run_op(32'h4049_0FDB, -1, 1'b1, dA);
        run_op(32'hC2F6_E979, -1, 1'b0, dB);
        check("b2b interval", dB - dA, 32'(L + 2));
        pulse_credit(2);

        // Randomized operations and credit traffic.
        for (int it = 0; it < 16; it++) begin
            if (m_cred == 0) begin
                r = L + 1 + int'($urandom_range(0, 3));
            end else begin
                case ($urandom_range(0, 2))
                    0:       r = -1;
                    1:       r = L;
                    default: r = L + 1;
                endcase
            end
            run_op($urandom, r, 1'b0, dx);
            pulse_credit(int'($urandom_range(0, 1)));
        end

        // Reset two cycles into EXEC aborts the word without a done.
        valid_in = 1'b1;
        data_in  = 32'hBF00_0000;
        tick();
        tick();
        tick();
        #2;
        rst      = 1'b0;
        valid_in = 1'b0;
        #1;
        m_cred   = C;
        m_ops    = 0;
        m_stalls = 0;
        for (int i = 0; i < 4; i++) m_res[i] = 32'd0;
        check_outputs("async reset", 1'b0, 1'b0);
        check_cred("async reset cred");
        tick();
        check_outputs("in reset", 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check_outputs("after reset", 1'b0, 1'b0);
        run_op(32'h0000_0001, -1, 1'b0, dx);
        check("nabs after reset", res_data[3], 32'h8000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
